apb_ram_responder: RTL and testbench
====================================

// Module: apb_ram_responder
// PURPOSE
//   Parametrised APB3/APB4 completer model: word RAM, programmable wait states, byte strobes, error injection.
//   Sits on the bus side of apb_emulator in block benches and replaces the constant ready=1 / rdata=0 stub.
//   Gives stimc-driven tests real read-back data, PREADY back-pressure, PSLVERR responses and protocol checking.
// PARAMETERS
//   ADDR_W     32   APB address width.
//   DATA_W     32   APB data width; must be 8, 16, 32 or 64.
//   DEPTH      256  RAM depth in DATA_W words; power of two.
//   WAIT_W     4    Width of the wait-state configuration.
//   PRIV_ONLY  0    1: an access with apb_prot_i[0]==0 is rejected with SLVERR.
// PORTS
//   apb_clk_i       in   1         APB clock; all state on the rising edge.
//   apb_resetn_i    in   1         Asynchronous, active-low reset.
//   apb_addr_i      in   ADDR_W    PADDR (byte address).
//   apb_sel_i       in   1         PSEL.
//   apb_enable_i    in   1         PENABLE.
//   apb_write_i     in   1         PWRITE.
//   apb_strb_i      in   DATA_W/8  PSTRB; one bit per byte lane.
//   apb_prot_i      in   3         PPROT.
//   apb_wdata_i     in   DATA_W    PWDATA.
//   apb_ready_o     out  1         PREADY.
//   apb_rdata_o     out  DATA_W    PRDATA.
//   apb_slverr_o    out  1         PSLVERR.
//   wait_cfg_i      in   WAIT_W    Wait states to insert per transfer.
//   access_cnt_o    out  16        Completed transfers; saturates at 16'hFFFF.
//   protocol_err_o  out  1         Sticky protocol-violation flag.
// BEHAVIOUR
//   Reset: state=IDLE, wait counter=0, access_cnt_o=0, protocol_err_o=0.
//     Outputs during reset: apb_ready_o=0, apb_slverr_o=0, apb_rdata_o=0.
//     RAM contents are not reset and survive a reset.
//   Derived constants: ALIGN=log2(DATA_W/8), IDXW=log2(DEPTH), word index=addr[ALIGN+IDXW-1:ALIGN].
//   FSM: IDLE -> ACCESS -> IDLE.
//     IDLE, sel=1 & enable=0 (setup): go to ACCESS; load counter from wait_cfg_i; latch error decision.
//     ACCESS, enable=1 & counter!=0: decrement counter; ready=0.
//     ACCESS, counter==0: ready=1; complete the transfer; return to IDLE.
//   Back-to-back: the cycle after the ready cycle may be a new setup phase. No idle cycle is required.
//   Output timing: apb_ready_o = (state==ACCESS) && (counter==0).
//     Decoded from registers only; no combinational path from APB inputs.
//     Latency: wait_cfg_i=N gives ready in access cycle N+1. N=0 gives a zero-wait APB transfer.
//   wait_cfg_i is sampled only at setup. Changes during a transfer have no effect until the next setup.
//   Error decision, latched at setup. Any of the following gives an error:
//     address bits above ALIGN+IDXW-1 are nonzero;
//     address bits [ALIGN-1:0] are nonzero (misaligned);
//     PRIV_ONLY=1 and prot[0]==0.
//   Ready cycle, write: RAM lanes with strb=1 take wdata; lanes with strb=0 are unchanged.
//     On error, no lane is written.
//   Ready cycle, read: rdata = RAM word, or 0 on error. rdata=0 in every cycle where ready=0.
//   apb_slverr_o = ready & error. slverr is never asserted without ready.
//   access_cnt_o increments on every ready cycle (including SLVERR completions) and saturates.
//   Protocol violations set protocol_err_o=1 (sticky until reset):
//     sel drops while in ACCESS: abort to IDLE; no write; no count increment.
//     enable=0 while in ACCESS: abort to IDLE; no write; no count increment.
//     enable=1 while in IDLE: no state change.
//   Reset mid-transfer: FSM returns to IDLE immediately (asynchronous); any pending write is dropped.
// TESTING (DATA_W=32, DEPTH=256, PRIV_ONLY=0 unless noted)
//   1 wait=0: write 32'hDEADBEEF to 0x10 (strb F), then read 0x10.
//     -> ready in first access cycle; rdata=DEADBEEF; slverr=0; access_cnt=2.
//   2 wait=3: read 0x10.
//     -> ready=0 for 3 access cycles, ready=1 in 4th; rdata=0 while waiting.
//   3 Write FFFFFFFF, then 11223344 with strb 4'b0101, then read.
//     -> rdata=FF22FF44.
//   4 Write 0x400 and write 0x2 (error cases).
//     -> each: ready=1 and slverr=1; word 0 unchanged on read-back. With PRIV_ONLY=1, prot=000 -> slverr.
//   5 wait=5: drop sel in 2nd access cycle.
//     -> protocol_err_o=1; no write; next transfer completes normally.
//   6 apb_resetn_i low during a wait state.
//     -> ready=0, access_cnt=0, protocol_err=0 immediately; earlier RAM data still reads back.

Source files
------------

// File: rtl/apb_ram_responder.sv
// APB3/APB4 completer: word RAM with byte strobes, programmable wait states, SLVERR injection, protocol checking.
// Latency: wait_cfg_i=N gives PREADY in access cycle N+1 (N=0 is a zero-wait transfer); back-to-back setups allowed.
// Backpressure: PREADY held low for N access cycles; ready/slverr/rdata decode from registered state only.
module apb_ram_responder #(
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32,
  parameter int DEPTH     = 256,
  parameter int WAIT_W    = 4,
  parameter int PRIV_ONLY = 0
) (
  input  logic                  apb_clk_i,
  input  logic                  apb_resetn_i,
  input  logic [ADDR_W-1:0]     apb_addr_i,
  input  logic                  apb_sel_i,
  input  logic                  apb_enable_i,
  input  logic                  apb_write_i,
  input  logic [DATA_W/8-1:0]   apb_strb_i,
  input  logic [2:0]            apb_prot_i,
  input  logic [DATA_W-1:0]     apb_wdata_i,
  output logic                  apb_ready_o,
  output logic [DATA_W-1:0]     apb_rdata_o,
  output logic                  apb_slverr_o,
  input  logic [WAIT_W-1:0]     wait_cfg_i,
  output logic [15:0]           access_cnt_o,
  output logic                  protocol_err_o
);

  localparam int STRB_W = DATA_W / 8;
  localparam int ALIGN  = $clog2(STRB_W);
  localparam int IDXW   = $clog2(DEPTH);
  localparam logic [ADDR_W-1:0] ALIGN_MASK = ADDR_W'((1 << ALIGN) - 1);

  typedef enum logic {IDLE, ACCESS} state_t;

  state_t              state_q;
  logic [WAIT_W-1:0]   cnt_q;
  logic                err_q;
  logic                write_q;
  logic [IDXW-1:0]     idx_q;
  logic [15:0]         access_cnt_q;
  logic                perr_q;
  logic [DATA_W-1:0]   mem [DEPTH];

  logic setup_err;
  logic xfer_ok;
  logic ram_we;
  logic unused_prot;

  assign setup_err = ((apb_addr_i >> (ALIGN + IDXW)) != '0) ||
                     ((apb_addr_i & ALIGN_MASK) != '0) ||
                     ((PRIV_ONLY != 0) && !apb_prot_i[0]);
  assign unused_prot = ^apb_prot_i[2:1];

  assign apb_ready_o  = (state_q == ACCESS) && (cnt_q == '0);
  assign apb_slverr_o = apb_ready_o && err_q;
  assign apb_rdata_o  = (apb_ready_o && !err_q && !write_q) ? mem[idx_q] : '0;
  assign access_cnt_o   = access_cnt_q;
  assign protocol_err_o = perr_q;

  // A ready cycle only commits if the requester is still holding a valid access phase.
  assign xfer_ok = apb_ready_o && apb_sel_i && apb_enable_i;
  assign ram_we  = xfer_ok && write_q && !err_q;

  always_ff @(posedge apb_clk_i or negedge apb_resetn_i) begin
    if (!apb_resetn_i) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      err_q        <= 1'b0;
      write_q      <= 1'b0;
      idx_q        <= '0;
      access_cnt_q <= '0;
      perr_q       <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (apb_enable_i) begin
            perr_q <= 1'b1;
          end else if (apb_sel_i) begin
            state_q <= ACCESS;
            cnt_q   <= wait_cfg_i;
            err_q   <= setup_err;
            write_q <= apb_write_i;
            idx_q   <= apb_addr_i[ALIGN+IDXW-1:ALIGN];
          end
        end
        ACCESS: begin
          if (!apb_sel_i || !apb_enable_i) begin
            perr_q  <= 1'b1;
            state_q <= IDLE;
          end else if (cnt_q != '0) begin
            cnt_q <= cnt_q - WAIT_W'(1);
          end else begin
            state_q <= IDLE;
            if (access_cnt_q != 16'hFFFF) access_cnt_q <= access_cnt_q + 16'd1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // RAM contents deliberately survive reset.
  always_ff @(posedge apb_clk_i) begin
    if (ram_we) begin
      for (int b = 0; b < STRB_W; b++) begin
        if (apb_strb_i[b]) mem[idx_q][b*8 +: 8] <= apb_wdata_i[b*8 +: 8];
      end
    end
  end

endmodule

// File: tb/tb_apb_ram_responder.sv
// Directed bench for apb_ram_responder: one default instance plus a PRIV_ONLY=1 instance on the same bus.
module tb_apb_ram_responder;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic [31:0] addr = '0;
  logic        sel = 1'b0;
  logic        en = 1'b0;
  logic        write = 1'b0;
  logic [3:0]  strb = '0;
  logic [2:0]  prot = 3'b001;
  logic [31:0] wdata = '0;
  logic [3:0]  wait_cfg = '0;

  logic        ready0, slverr0, perr0;
  logic [31:0] rdata0;
  logic [15:0] cnt0;
  logic        ready1, slverr1, perr1;
  logic [31:0] rdata1;
  logic [15:0] cnt1;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  apb_ram_responder u_dut (
    .apb_clk_i(clk), .apb_resetn_i(resetn), .apb_addr_i(addr), .apb_sel_i(sel),
    .apb_enable_i(en), .apb_write_i(write), .apb_strb_i(strb), .apb_prot_i(prot),
    .apb_wdata_i(wdata), .apb_ready_o(ready0), .apb_rdata_o(rdata0), .apb_slverr_o(slverr0),
    .wait_cfg_i(wait_cfg), .access_cnt_o(cnt0), .protocol_err_o(perr0)
  );

  apb_ram_responder #(.PRIV_ONLY(1)) u_priv (
    .apb_clk_i(clk), .apb_resetn_i(resetn), .apb_addr_i(addr), .apb_sel_i(sel),
    .apb_enable_i(en), .apb_write_i(write), .apb_strb_i(strb), .apb_prot_i(prot),
    .apb_wdata_i(wdata), .apb_ready_o(ready1), .apb_rdata_o(rdata1), .apb_slverr_o(slverr1),
    .wait_cfg_i(wait_cfg), .access_cnt_o(cnt1), .protocol_err_o(perr1)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Entered and left at posedge+1; ends with sel low so the next call is a back-to-back setup.
  task automatic xfer(input logic wr, input logic [31:0] a, input logic [31:0] wd,
                      input logic [3:0] st, output logic [31:0] rd, output logic e0,
                      output logic e1, output int waits);
    logic [3:0] saved;
    logic       nz;
    logic       got;
    saved = wait_cfg;
    addr = a; write = wr; wdata = wd; strb = st; sel = 1'b1; en = 1'b0;
    @(posedge clk); #1;
    en = 1'b1;
    wait_cfg = ~saved;
    waits = 0; nz = 1'b0; got = 1'b0; rd = '0; e0 = 1'b0; e1 = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (ready0) begin
        got = 1'b1; rd = rdata0; e0 = slverr0; e1 = slverr1;
        break;
      end
      waits++;
      if (rdata0 != '0 || slverr0) nz = 1'b1;
    end
    chk("idle_outputs_while_waiting", nz, 1'b0);
    if (!got) chk("ready_timeout", 1'b0, 1'b1);
    @(posedge clk); #1;
    sel = 1'b0; en = 1'b0; wait_cfg = saved;
  endtask

  task automatic wr_chk(input string tag, input logic [31:0] a, input logic [31:0] wd,
                        input logic [3:0] st, input int exp_waits, input logic exp_err);
    logic [31:0] rd;
    logic        e0, e1;
    int          w;
    xfer(1'b1, a, wd, st, rd, e0, e1, w);
    chk({tag, "_waits"}, w, exp_waits);
    chk({tag, "_slverr"}, e0, exp_err);
  endtask

  task automatic rd_chk(input string tag, input logic [31:0] a, input logic [31:0] exp_rd,
                        input int exp_waits, input logic exp_err, input logic exp_err1);
    logic [31:0] rd;
    logic        e0, e1;
    int          w;
    xfer(1'b0, a, 32'h0, 4'h0, rd, e0, e1, w);
    chk({tag, "_waits"}, w, exp_waits);
    chk({tag, "_rdata"}, rd, exp_rd);
    chk({tag, "_slverr"}, e0, exp_err);
    chk({tag, "_slverr_priv"}, e1, exp_err1);
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ready", ready0, 1'b0);
    chk("rst_slverr", slverr0, 1'b0);
    chk("rst_rdata", rdata0, 32'h0);
    chk("rst_cnt", cnt0, 16'h0);
    chk("rst_perr", perr0, 1'b0);
    resetn = 1'b1;
    @(posedge clk); #1;

    // zero-wait write/read back-to-back
    wait_cfg = 4'd0;
    wr_chk("t1_wr", 32'h10, 32'hDEADBEEF, 4'hF, 0, 1'b0);
    rd_chk("t1_rd", 32'h10, 32'hDEADBEEF, 0, 1'b0, 1'b0);
    chk("t1_cnt", cnt0, 16'd2);

    // three wait states; the task scrambles wait_cfg mid-transfer
    wait_cfg = 4'd3;
    rd_chk("t2_rd", 32'h10, 32'hDEADBEEF, 3, 1'b0, 1'b0);

    // byte strobes
    wait_cfg = 4'd1;
    wr_chk("t3_wr_full", 32'h20, 32'hFFFFFFFF, 4'hF, 1, 1'b0);
    wr_chk("t3_wr_strb", 32'h20, 32'h11223344, 4'b0101, 1, 1'b0);
    rd_chk("t3_rd", 32'h20, 32'hFF22FF44, 1, 1'b0, 1'b0);
    chk("t3_cnt", cnt0, 16'd6);

    // error cases: out of range, misaligned, unprivileged on the PRIV_ONLY instance
    wait_cfg = 4'd0;
    wr_chk("t4_wr0", 32'h0, 32'hA5A5A5A5, 4'hF, 0, 1'b0);
    wr_chk("t4_wr_range", 32'h400, 32'h0, 4'hF, 0, 1'b1);
    wr_chk("t4_wr_misal", 32'h2, 32'h0, 4'hF, 0, 1'b1);
    rd_chk("t4_rd0", 32'h0, 32'hA5A5A5A5, 0, 1'b0, 1'b0);
    rd_chk("t4_rd_range", 32'h400, 32'h0, 0, 1'b1, 1'b1);
    prot = 3'b000;
    rd_chk("t4_rd_unpriv", 32'h0, 32'hA5A5A5A5, 0, 1'b0, 1'b1);
    prot = 3'b001;
    chk("t4_cnt", cnt0, 16'd12);

    // sel dropped in the second access cycle of a 5-wait write
    wr_chk("t5_prewr", 32'h30, 32'h0BADF00D, 4'hF, 0, 1'b0);
    chk("t5_perr_before", perr0, 1'b0);
    wait_cfg = 4'd5;
    addr = 32'h30; write = 1'b1; wdata = 32'h12345678; strb = 4'hF; sel = 1'b1; en = 1'b0;
    @(posedge clk); #1;
    en = 1'b1;
    @(posedge clk); #1;
    sel = 1'b0;
    @(negedge clk);
    chk("t5_ready_on_drop", ready0, 1'b0);
    @(posedge clk); #1;
    en = 1'b0;
    @(negedge clk);
    chk("t5_perr", perr0, 1'b1);
    chk("t5_cnt_no_inc", cnt0, 16'd13);
    @(posedge clk); #1;
    wait_cfg = 4'd0;
    rd_chk("t5_rd", 32'h30, 32'h0BADF00D, 0, 1'b0, 1'b0);
    chk("t5_cnt", cnt0, 16'd14);

    // asynchronous reset during a wait state
    wait_cfg = 4'd5;
    addr = 32'h10; write = 1'b0; sel = 1'b1; en = 1'b0;
    @(posedge clk); #1;
    en = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    chk("t6_waiting", ready0, 1'b0);
    #2;
    resetn = 1'b0;
    #1;
    chk("t6_ready", ready0, 1'b0);
    chk("t6_cnt", cnt0, 16'd0);
    chk("t6_perr", perr0, 1'b0);
    chk("t6_rdata", rdata0, 32'h0);
    sel = 1'b0; en = 1'b0;
    @(posedge clk); #1;
    resetn = 1'b1;
    @(posedge clk); #1;
    wait_cfg = 4'd0;
    rd_chk("t6_rd10", 32'h10, 32'hDEADBEEF, 0, 1'b0, 1'b0);
    rd_chk("t6_rd20", 32'h20, 32'hFF22FF44, 0, 1'b0, 1'b0);
    chk("t6_cnt_after", cnt0, 16'd2);
    chk("t6_cnt_priv", cnt1, 16'd2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
